pc_sequencer: RTL

PC_SEQUENCER -- requirements
Module: pc_sequencer

---
 rtl/pc_sequencer.sv | 123 ++++++++++++
 1 files changed

// File: rtl/pc_sequencer.sv
// Next-PC sequencer: IDLE/RUN/STALL/HALT control, redirects and a return-address stack.
// nextAddress and fetch_valid are combinational; state and stack flags are registered.
module pc_sequencer #(
  parameter int unsigned ADDR_W      = 3,
  parameter int unsigned STACK_DEPTH = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              stall,
  input  logic              halt_req,
  input  logic              branch_taken,
  input  logic              jump,
  input  logic              call,
  input  logic              ret,
  input  logic [ADDR_W-1:0] target,
  input  logic [ADDR_W-1:0] Address,
  output logic [ADDR_W-1:0] nextAddress,
  output logic              fetch_valid,
  output logic [1:0]        state,
  output logic              stack_overflow,
  output logic              stack_underflow
);

  localparam int unsigned PTR_W   = (STACK_DEPTH > 1) ? $clog2(STACK_DEPTH) : 1;
  localparam int unsigned DEPTH_W = $clog2(STACK_DEPTH + 1);

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    RUN   = 2'b01,
    STALL = 2'b10,
    HALT  = 2'b11
  } state_t;

  state_t              state_q, state_d;
  logic [DEPTH_W-1:0]  depth_q;
  logic [ADDR_W-1:0]   stack_mem [STACK_DEPTH];
  logic                push, pop, set_ovf, set_unf;
  logic                full, empty;
  logic [ADDR_W-1:0]   seq_addr, top_addr;

  assign seq_addr = Address + ADDR_W'(1);
  assign full     = (depth_q == DEPTH_W'(STACK_DEPTH));
  assign empty    = (depth_q == '0);
  assign top_addr = stack_mem[PTR_W'(depth_q - DEPTH_W'(1))];
  assign state    = state_q;

  // State, depth and sticky flags; stack entries are left uncleared by reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q         <= IDLE;
      depth_q         <= '0;
      stack_overflow  <= 1'b0;
      stack_underflow <= 1'b0;
    end else begin
      state_q <= state_d;
      if (push) begin
        stack_mem[PTR_W'(depth_q)] <= seq_addr;
        depth_q                    <= depth_q + DEPTH_W'(1);
      end else if (pop) begin
        depth_q <= depth_q - DEPTH_W'(1);
      end
      if (set_ovf) stack_overflow  <= 1'b1;
      if (set_unf) stack_underflow <= 1'b1;
    end
  end

  // Next-state, next-PC and stack control; RUN priority is halt, stall, ret, call, jump/branch.
  always_comb begin
    state_d     = state_q;
    nextAddress = Address;
    fetch_valid = 1'b0;
    push        = 1'b0;
    pop         = 1'b0;
    set_ovf     = 1'b0;
    set_unf     = 1'b0;
    if (reset) begin
      nextAddress = '0;
      state_d     = IDLE;
    end else begin
      case (state_q)
        IDLE: begin
          nextAddress = '0;
          if (start) state_d = RUN;
        end
        RUN: begin
          fetch_valid = ~stall & ~halt_req;
          if (halt_req) begin
            state_d = HALT;
          end else if (stall) begin
            state_d = STALL;
          end else if (ret) begin
            if (empty) begin
              set_unf = 1'b1;
              state_d = HALT;
            end else begin
              nextAddress = top_addr;
              pop         = 1'b1;
            end
          end else if (call) begin
            if (full) begin
              set_ovf = 1'b1;
              state_d = HALT;
            end else begin
              nextAddress = target;
              push        = 1'b1;
            end
          end else if (jump || branch_taken) begin
            nextAddress = target;
          end else begin
            nextAddress = seq_addr;
          end
        end
        STALL: begin
          if (halt_req)    state_d = HALT;
          else if (!stall) state_d = RUN;
        end
        default: state_d = HALT;
      endcase
    end
  end

endmodule
